// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_arbiter                                                 |
// | Brief    : Round-robin arbiter sharing one UART TX among NUM_REQ sources,  |
// |            with per-message locking and a lock-stall timeout.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic [NUM_REQ-1:0]     i_Req_Valid,
    input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
    input  logic [NUM_REQ-1:0]     i_Req_Last,
    output logic [NUM_REQ-1:0]     o_Req_Ack,
    output logic [NUM_REQ-1:0]     o_Grant,
    output logic                   o_Lock_Timeout,
    output logic                   o_TX_DV,
    output logic [7:0]             o_TX_Byte,
    input  logic                   i_TX_Active,
    input  logic                   i_TX_Done
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(NUM_REQ - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT   = c_CNT_W'(LOCK_TIMEOUT);

    localparam logic [0:0] c_IDLE      = 1'b0;
    localparam logic [0:0] c_WAIT_DONE = 1'b1;

    logic [0:0]          r_state,   w_state_nxt;
    logic                r_lock,    w_lock_nxt;
    logic                r_last,    w_last_nxt;
    logic [c_IDX_W-1:0]  r_owner,   w_owner_nxt;
    logic [c_IDX_W-1:0]  r_ptr,     w_ptr_nxt;
    logic [c_CNT_W-1:0]  r_cnt,     w_cnt_nxt;
    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic [NUM_REQ-1:0]  r_grant,   w_grant_nxt;
    logic [NUM_REQ-1:0]  r_ack,     w_ack_nxt;
    logic                r_tx_dv,   w_tx_dv_nxt;
    logic [7:0]          r_tx_byte, w_tx_byte_nxt;
    logic                r_timeout, w_timeout_nxt;

    logic                w_found;
    logic [c_IDX_W-1:0]  w_rr_idx;
    logic [c_IDX_W-1:0]  w_probe;
    logic                w_take;
    logic [c_IDX_W-1:0]  w_take_idx;

    function automatic logic [c_IDX_W-1:0] f_wrap_inc(input logic [c_IDX_W-1:0] idx);
        if (idx == c_LAST_IDX) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    assign w_cnt_inc = r_cnt + 1'b1;

    // Probe from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_found  = 1'b0;
        w_rr_idx = r_ptr;
        w_probe  = r_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_probe = c_IDX_W'((int'(r_ptr) + i) % NUM_REQ);
            if (i_Req_Valid[w_probe]) begin
                w_found  = 1'b1;
                w_rr_idx = w_probe;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_lock_nxt    = r_lock;
        w_last_nxt    = r_last;
        w_owner_nxt   = r_owner;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_grant_nxt   = r_grant;
        w_ack_nxt     = '0;
        w_tx_dv_nxt   = 1'b0;
        w_tx_byte_nxt = r_tx_byte;
        w_timeout_nxt = 1'b0;
        w_take        = 1'b0;
        w_take_idx    = r_owner;

        case (r_state)
            c_IDLE: begin
                if (r_lock) begin
                    // A valid byte from the owner beats an expiring counter.
                    if (i_Req_Valid[r_owner] && !i_TX_Active) begin
                        w_take     = 1'b1;
                        w_take_idx = r_owner;
                    end else if (!i_Req_Valid[r_owner]) begin
                        if (w_cnt_inc == c_TIMEOUT) begin
                            w_lock_nxt    = 1'b0;
                            w_grant_nxt   = '0;
                            w_timeout_nxt = 1'b1;
                            w_ptr_nxt     = f_wrap_inc(r_owner);
                            w_cnt_nxt     = '0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                end else if (!i_TX_Active && w_found) begin
                    w_take     = 1'b1;
                    w_take_idx = w_rr_idx;
                end
            end

            c_WAIT_DONE: begin
                if (i_TX_Done) begin
                    w_state_nxt = c_IDLE;
                    if (r_last) begin
                        w_lock_nxt  = 1'b0;
                        w_grant_nxt = '0;
                        w_ptr_nxt   = f_wrap_inc(r_owner);
                    end
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase

        if (w_take) begin
            w_state_nxt   = c_WAIT_DONE;
            w_owner_nxt   = w_take_idx;
            w_last_nxt    = i_Req_Last[w_take_idx];
            w_lock_nxt    = !i_Req_Last[w_take_idx];
            w_grant_nxt   = NUM_REQ'(1) << w_take_idx;
            w_ack_nxt     = NUM_REQ'(1) << w_take_idx;
            w_tx_dv_nxt   = 1'b1;
            w_tx_byte_nxt = i_Req_Byte[int'(w_take_idx) * 8 +: 8];
            w_cnt_nxt     = '0;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state   <= c_IDLE;
            r_lock    <= 1'b0;
            r_last    <= 1'b0;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_ack     <= '0;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock    <= w_lock_nxt;
            r_last    <= w_last_nxt;
            r_owner   <= w_owner_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_grant   <= w_grant_nxt;
            r_ack     <= w_ack_nxt;
            r_tx_dv   <= w_tx_dv_nxt;
            r_tx_byte <= w_tx_byte_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign o_Req_Ack      = r_ack;
    assign o_Grant        = r_grant;
    assign o_Lock_Timeout = r_timeout;
    assign o_TX_DV        = r_tx_dv;
    assign o_TX_Byte      = r_tx_byte;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_tx_arbiter                                              |
// | Brief    : Directed bench for uart_tx_arbiter with a UART TX/RX loopback.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

    localparam int c_NUM_REQ = 4;
    localparam int c_TIMEOUT = 16;
    localparam int c_CPB     = 217;
    localparam int c_WAIT    = 4000;

    logic        clk = 1'b0;
    logic        i_Reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_byte = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  o_Req_Ack;
    logic [3:0]  o_Grant;
    logic        o_Lock_Timeout;
    logic        o_TX_DV;
    logic [7:0]  o_TX_Byte;

    logic        tx_busy = 1'b0;
    logic        tx_done = 1'b0;
    logic [9:0]  tx_shift = '1;
    int          tx_bit = 0;
    int          tx_clk = 0;
    logic        tx_serial;

    logic [1:0]  rx_st = '0;
    int          rx_cnt = 0;
    int          rx_bit = 0;
    logic [7:0]  rx_sh = '0;
    logic [7:0]  rx_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #20 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (c_NUM_REQ),
        .LOCK_TIMEOUT (c_TIMEOUT)
    ) dut (
        .i_Clock        (clk),
        .i_Reset        (i_Reset),
        .i_Req_Valid    (req_valid),
        .i_Req_Byte     (req_byte),
        .i_Req_Last     (req_last),
        .o_Req_Ack      (o_Req_Ack),
        .o_Grant        (o_Grant),
        .o_Lock_Timeout (o_Lock_Timeout),
        .o_TX_DV        (o_TX_DV),
        .o_TX_Byte      (o_TX_Byte),
        .i_TX_Active    (tx_busy),
        .i_TX_Done      (tx_done)
    );

    // UART TX model: Done pulses in the same cycle Active falls; not reset.
    assign tx_serial = tx_busy ? tx_shift[tx_bit] : 1'b1;
    always @(posedge clk) begin
        tx_done <= 1'b0;
        if (!tx_busy) begin
            if (o_TX_DV) begin
                tx_busy  <= 1'b1;
                tx_shift <= {1'b1, o_TX_Byte, 1'b0};
                tx_bit   <= 0;
                tx_clk   <= 0;
            end
        end else if (tx_clk == c_CPB - 1) begin
            tx_clk <= 0;
            if (tx_bit == 9) begin
                tx_busy <= 1'b0;
                tx_done <= 1'b1;
            end else begin
                tx_bit <= tx_bit + 1;
            end
        end else begin
            tx_clk <= tx_clk + 1;
        end
    end

    // UART RX model sampling mid-bit.
    always @(posedge clk) begin
        case (rx_st)
            2'd0: if (!tx_serial) begin rx_st <= 2'd1; rx_cnt <= 0; end
            2'd1: if (rx_cnt == c_CPB / 2) begin
                      rx_cnt <= 0;
                      rx_bit <= 0;
                      rx_st  <= tx_serial ? 2'd0 : 2'd2;
                  end else rx_cnt <= rx_cnt + 1;
            2'd2: if (rx_cnt == c_CPB - 1) begin
                      rx_cnt        <= 0;
                      rx_sh[rx_bit] <= tx_serial;
                      if (rx_bit == 7) rx_st <= 2'd3;
                      else rx_bit <= rx_bit + 1;
                  end else rx_cnt <= rx_cnt + 1;
            default: if (rx_cnt == c_CPB - 1) begin
                      rx_st <= 2'd0;
                      if (tx_serial) rx_q.push_back(rx_sh);
                  end else rx_cnt <= rx_cnt + 1;
        endcase
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int n, input logic [7:0] b, input logic l, input logic v);
        req_byte[n*8 +: 8] = b;
        req_last[n]        = l;
        req_valid[n]       = v;
    endtask

    // Waits for the Done pulse and checks o_Grant held steady while waiting.
    task automatic wait_done(input string tag, input logic [3:0] exp_grant);
        logic [3:0] bad = exp_grant;
        bit         got = 1'b0;
        for (int i = 0; i < c_WAIT; i++) begin
            tick();
            if (o_Grant !== exp_grant) bad = o_Grant;
            if (tx_done) begin
                got = 1'b1;
                break;
            end
        end
        n_tests++;
        assert (got) else begin
            n_fail++;
            $error("FAIL %s_done: observed no TX done, expected done within %0d cycles", tag, c_WAIT);
        end
        chk({tag, "_grant_hold"}, 32'(bad), 32'(exp_grant));
    endtask

    task automatic chk_rx(input string tag, input logic [7:0] exp);
        bit got = 1'b0;
        for (int i = 0; i < c_WAIT; i++) begin
            if (rx_q.size() > 0) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        n_tests++;
        assert (got) else begin
            n_fail++;
            $error("FAIL %s: observed no RX byte, expected %h", tag, exp);
        end
        if (got) chk(tag, 32'(rx_q.pop_front()), 32'(exp));
    endtask

    task automatic do_reset();
        for (int i = 0; i < c_WAIT && tx_busy; i++) tick();
        req_valid = '0;
        i_Reset   = 1'b1;
        tick();
        tick();
        i_Reset = 1'b0;
        rx_q.delete();
    endtask

    initial begin
        logic [3:0] bad4;
        logic       bad1;

        // Reset state
        tick();
        tick();
        chk("rst_grant", 32'(o_Grant), 32'h0);
        chk("rst_ack", 32'(o_Req_Ack), 32'h0);
        chk("rst_dv", 32'(o_TX_DV), 32'h0);
        chk("rst_byte", 32'(o_TX_Byte), 32'h0);
        chk("rst_to", 32'(o_Lock_Timeout), 32'h0);
        i_Reset = 1'b0;

        // Single byte from req1
        set_req(1, 8'h37, 1'b1, 1'b1);
        tick();
        chk("single_dv", 32'(o_TX_DV), 32'h1);
        chk("single_byte", 32'(o_TX_Byte), 32'h37);
        chk("single_ack", 32'(o_Req_Ack), 32'h2);
        chk("single_grant", 32'(o_Grant), 32'h2);
        req_valid[1] = 1'b0;
        tick();
        chk("single_dv_pulse", 32'(o_TX_DV), 32'h0);
        chk("single_ack_pulse", 32'(o_Req_Ack), 32'h0);
        wait_done("single", 4'b0010);
        tick();
        chk("single_release", 32'(o_Grant), 32'h0);
        chk_rx("single_rx", 8'h37);

        // Fairness: all four hold single Last bytes
        do_reset();
        for (int n = 0; n < 4; n++) set_req(n, 8'h10 + 8'(n), 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                tick();
            end else begin
                wait_done("fair", 4'(1 << ((i - 1) % 4)));
                tick();
                chk("fair_gap", 32'(o_TX_DV), 32'h0);
                tick();
            end
            chk("fair_dv", 32'(o_TX_DV), 32'h1);
            chk("fair_byte", 32'(o_TX_Byte), 32'h10 + 32'(i % 4));
            chk("fair_ack", 32'(o_Req_Ack), 32'(1 << (i % 4)));
        end
        req_valid = '0;
        wait_done("fair_end", 4'b0010);
        for (int i = 0; i < 6; i++) chk_rx("fair_rx", 8'h10 + 8'(i % 4));

        // Lock: req2 message A1,A2,A3 while req0 waits with 0x55
        do_reset();
        set_req(2, 8'hA1, 1'b0, 1'b1);
        tick();
        chk("lock_byte1", 32'(o_TX_Byte), 32'hA1);
        chk("lock_grant1", 32'(o_Grant), 32'h4);
        set_req(0, 8'h55, 1'b1, 1'b1);
        set_req(2, 8'hA2, 1'b0, 1'b1);
        wait_done("lock1", 4'b0100);
        tick();
        tick();
        chk("lock_dv2", 32'(o_TX_DV), 32'h1);
        chk("lock_byte2", 32'(o_TX_Byte), 32'hA2);
        set_req(2, 8'hA3, 1'b1, 1'b1);
        wait_done("lock2", 4'b0100);
        tick();
        tick();
        chk("lock_byte3", 32'(o_TX_Byte), 32'hA3);
        chk("lock_ack3", 32'(o_Req_Ack), 32'h4);
        req_valid[2] = 1'b0;
        wait_done("lock3", 4'b0100);
        tick();
        chk("lock_release", 32'(o_Grant), 32'h0);
        tick();
        chk("lock_next_byte", 32'(o_TX_Byte), 32'h55);
        chk("lock_next_grant", 32'(o_Grant), 32'h1);
        req_valid[0] = 1'b0;
        wait_done("lock4", 4'b0001);
        chk_rx("lock_rx1", 8'hA1);
        chk_rx("lock_rx2", 8'hA2);
        chk_rx("lock_rx3", 8'hA3);
        chk_rx("lock_rx4", 8'h55);

        // Timeout: req1 stalls mid-message, req3 waiting
        do_reset();
        set_req(1, 8'h01, 1'b0, 1'b1);
        tick();
        chk("to_byte1", 32'(o_TX_Byte), 32'h01);
        req_valid[1] = 1'b0;
        set_req(3, 8'h33, 1'b1, 1'b1);
        wait_done("to1", 4'b0010);
        bad1 = 1'b0;
        bad4 = 4'b0010;
        for (int i = 0; i < c_TIMEOUT; i++) begin
            tick();
            if (o_Lock_Timeout !== 1'b0) bad1 = o_Lock_Timeout;
            if (o_Grant !== 4'b0010) bad4 = o_Grant;
        end
        chk("to_early_pulse", 32'(bad1), 32'h0);
        chk("to_hold_grant", 32'(bad4), 32'h2);
        tick();
        chk("to_pulse", 32'(o_Lock_Timeout), 32'h1);
        chk("to_grant_clear", 32'(o_Grant), 32'h0);
        tick();
        chk("to_pulse_end", 32'(o_Lock_Timeout), 32'h0);
        chk("to_next_dv", 32'(o_TX_DV), 32'h1);
        chk("to_next_byte", 32'(o_TX_Byte), 32'h33);
        chk("to_next_grant", 32'(o_Grant), 32'h8);
        req_valid[3] = 1'b0;
        wait_done("to2", 4'b1000);
        chk_rx("to_rx1", 8'h01);
        chk_rx("to_rx2", 8'h33);

        // Timeout race: owner returns on the expiry cycle
        do_reset();
        set_req(1, 8'h01, 1'b0, 1'b1);
        tick();
        req_valid[1] = 1'b0;
        wait_done("race1", 4'b0010);
        for (int i = 0; i < c_TIMEOUT; i++) tick();
        set_req(1, 8'h02, 1'b1, 1'b1);
        tick();
        chk("race_dv", 32'(o_TX_DV), 32'h1);
        chk("race_byte", 32'(o_TX_Byte), 32'h02);
        chk("race_no_pulse", 32'(o_Lock_Timeout), 32'h0);
        chk("race_grant", 32'(o_Grant), 32'h2);
        req_valid[1] = 1'b0;
        wait_done("race2", 4'b0010);
        chk_rx("race_rx1", 8'h01);
        chk_rx("race_rx2", 8'h02);

        // Reset while the UART is mid-byte
        do_reset();
        set_req(0, 8'h5A, 1'b0, 1'b1);
        tick();
        chk("mid_byte1", 32'(o_TX_Byte), 32'h5A);
        set_req(0, 8'hC3, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        chk("mid_rst_active", 32'(tx_busy), 32'h1);
        chk("mid_rst_grant", 32'(o_Grant), 32'h0);
        chk("mid_rst_byte", 32'(o_TX_Byte), 32'h0);
        bad1 = 1'b0;
        for (int i = 0; i < c_WAIT; i++) begin
            tick();
            if (o_TX_DV !== 1'b0) bad1 = o_TX_DV;
            if (tx_done) break;
        end
        chk("mid_no_dv_while_active", 32'(bad1), 32'h0);
        tick();
        chk("mid_dv", 32'(o_TX_DV), 32'h1);
        chk("mid_byte2", 32'(o_TX_Byte), 32'hC3);
        chk("mid_ack", 32'(o_Req_Ack), 32'h1);
        req_valid[0] = 1'b0;
        wait_done("mid", 4'b0001);
        chk_rx("mid_rx1", 8'h5A);
        chk_rx("mid_rx2", 8'hC3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmit serializer (CLKS_PER_BIT-style byte TX with DV/Active/Done handshake) among NUM_REQ on-chip requesters. It uses round-robin arbitration with per-message locking, so multi-byte messages from one requester are never interleaved with another's. A lock-timeout counter releases a stalled requester. It sits between the command/telemetry producers and the single UART TX instance on the Go Board top level.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- LOCK_TIMEOUT, 1024, idle clocks a locked requester may stall before its lock is revoked (>=1)
- i_Clock  in  1  system clock (25 MHz on the Go Board)
- i_Reset  in  1  synchronous, active-high reset
- i_Req_Valid  in  NUM_REQ  bit n: requester n presents a byte; held until its ack
- i_Req_Byte  in  8*NUM_REQ  byte of requester n at bits [8n+7:8n]
- i_Req_Last  in  NUM_REQ  bit n: the presented byte ends requester n's message
- o_Req_Ack  out  NUM_REQ  one-cycle pulse: byte of requester n accepted
- o_Grant  out  NUM_REQ  one-hot current/locked owner; 0 when none
- o_Lock_Timeout  out  1  one-cycle pulse when a lock is revoked by timeout
- o_TX_DV  out  1  one-cycle load strobe to the UART TX
- o_TX_Byte  out  8  byte to the UART TX; valid when o_TX_DV=1
- i_TX_Active  in  1  UART TX busy serializing
- i_TX_Done  in  1  UART TX one-cycle pulse after the stop bit

## Operation
- States: IDLE, WAIT_DONE.
- Reset values: state IDLE; all outputs 0; lock clear; RR pointer 0; timeout counter 0.
- IDLE, no lock:
  - Requires i_TX_Active=0.
  - Searches i_Req_Valid starting at the pointer index and wrapping modulo NUM_REQ; takes the first set bit n.
  - On the next edge: o_TX_DV=1, o_TX_Byte=byte n, o_Req_Ack[n]=1, o_Grant=one-hot n, lock=!i_Req_Last[n]; go to WAIT_DONE.
- IDLE, locked to n:
  - Only i_Req_Valid[n] is considered; other requesters are ignored.
  - While i_Req_Valid[n]=0, the timeout counter increments each clock.
  - When the counter reaches LOCK_TIMEOUT: clear lock and o_Grant, pulse o_Lock_Timeout, set pointer to (n+1) mod NUM_REQ, clear the counter. Normal arbitration resumes the following cycle.
  - If i_Req_Valid[n]=1 on the same cycle the counter would expire, the grant wins and no timeout pulse is issued.
- WAIT_DONE:
  - o_TX_DV and o_Req_Ack return to 0 after one cycle; i_Req_Valid is ignored.
  - On i_TX_Done=1, return to IDLE.
  - If the byte just sent had Last=1: clear lock and o_Grant, and set pointer to (n+1) mod NUM_REQ.
  - Otherwise keep the lock; the pointer is unchanged.
- Any grant clears the timeout counter.
- Requester rule: after seeing o_Req_Ack[n], the requester drops i_Req_Valid[n] or presents its next byte by the following cycle.
- Reset mid-operation forces all reset values immediately, including during WAIT_DONE. A transmission still in the UART TX completes on its own. No new o_TX_DV is issued until i_TX_Active is sampled low.

## Timing
- Grant latency: i_Req_Valid sampled high in IDLE (TX idle) at edge k -> o_TX_DV, o_Req_Ack, o_Grant high after edge k.
- o_TX_DV and o_Req_Ack are high for exactly one cycle and in the same cycle.
- Byte-to-byte: the next o_TX_DV comes at the earliest 1 cycle after i_TX_Done, giving 2 cycles of IDLE turnaround including the DV cycle.
- o_Grant is stable from grant until release, either at i_TX_Done of the Last byte or at the timeout.
- Counter width: $clog2(LOCK_TIMEOUT+1) bits; saturation is unreachable.
- Arbitration is purely registered; no output is combinational from inputs.

## Test plan
The bench uses UART_TX -> UART_RX loopback with CLKS_PER_BIT=217, a 40 ns clock and NUM_REQ=4.
- Single byte: req1 sends 0x37 with Last=1 -> one o_TX_DV with 0x37 and o_Req_Ack=0010 on the same cycle; o_Grant=0010 until i_TX_Done, then 0; RX receives 0x37.
- Fairness: all four requesters hold single Last bytes 0x10..0x13, refilled after each ack -> RX order 0x10,0x11,0x12,0x13,0x10,... with the pointer wrapping after req3.
- Lock: req2 sends 0xA1, 0xA2, 0xA3 (Last on 0xA3) while req0 is continuously valid with 0x55 -> RX sees A1,A2,A3,55 with no interleave; o_Grant=0100 throughout the message.
- Timeout: LOCK_TIMEOUT=16; req1 sends 0x01 (Last=0) then goes quiet while req3 is valid with 0x33 -> exactly 16 IDLE clocks after i_TX_Done, o_Lock_Timeout pulses; the next cycle grants req3 and RX receives 0x33.
- Timeout race: the locked requester reasserts valid on the expiry cycle -> it is granted and o_Lock_Timeout stays 0.
- Reset mid-byte: i_Reset held for 1 cycle in WAIT_DONE while i_TX_Active=1 -> all outputs 0 and lock cleared the next cycle; a pending req0 is not strobed until i_TX_Active falls; the following byte is then received intact.
